load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Core-side initiator for data-memory accesses; sits between the execute stage and the word-organised data memory.
- Accepts one load/store request per handshake and decodes funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Drives a word-aligned memory request with byte strobes and waits for acknowledge.
- Returns a sign- or zero-extended load result, or an error flag for misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in ACCESS without mem_ack before bus error; 0 disables the timeout.
- CNT_WIDTH, 8: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal funct3, or timeout
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables; 0000 on reads
- mem_ack  in  1  memory completed access this cycle
- mem_rdata  in  32  read word, valid when mem_ack

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - state=IDLE.
  - All outputs 0, including req_ready.
  - Captured request, timeout counter and response registers cleared.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered or decoded from state only; no combinational path from req_* to mem_*.
- IDLE:
  - req_ready=1.
  - Request accepted when req_valid & req_ready; capture is_store, funct3, addr, wdata.
  - Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010. Anything else is illegal.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
  - Illegal or misaligned -> RESP with err=1; no mem_req is ever issued.
  - Otherwise -> ACCESS.
- ACCESS:
  - mem_req=1; mem_we, mem_addr, mem_wdata, mem_wstrb held stable until exit.
  - On mem_ack: for loads, latch the extracted word; -> RESP with err=0.
  - Timeout counter starts at 0 on entry and increments each cycle without mem_ack.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with no ack: -> RESP with err=1, rdata=0.
  - mem_ack in the same cycle as the timeout: ack wins.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err; -> IDLE. req_ready=0 in ACCESS and RESP.
- Latency:
  - Request accepted at edge N; mem_req high from cycle N+1.
  - Earliest ack in cycle N+1; resp_valid in cycle N+2.
  - Best-case throughput: one access per 3 cycles.
  - Error responses: resp_valid in cycle N+1.
- Store lane formatting (o = addr[1:0]):
  - SB: wdata={4{d[7:0]}}, wstrb=0001<<o.
  - SH: wdata={2{d[15:0]}}, wstrb=0011<<o.
  - SW: wdata=d, wstrb=1111.
- Load extraction: w = mem_rdata >> (8*o).
  - LB: sext(w[7:0]); LBU: zext(w[7:0]).
  - LH: sext(w[15:0]); LHU: zext(w[15:0]).
  - LW: w.
- mem_ack outside ACCESS is ignored.
- Store response: resp_rdata=0.
- req_valid while req_ready=0 is ignored; the core must hold it.
- Reset mid-ACCESS drops mem_req asynchronously; no response is produced.

Test Plan:
- SW addr=0x0000_0010 data=0xDEADBEEF, ack 1 cycle after mem_req -> mem_addr=0x10, wstrb=1111, wdata=0xDEADBEEF, mem_we=1; resp_valid 2 cycles after accept with err=0, rdata=0.
- SB addr=0x13 data=0x0000_00A5 -> mem_addr=0x10, wstrb=1000, wdata=0xA5A5A5A5; SH addr=0x12 data=0x1234 -> wstrb=1100, wdata=0x12341234.
- Loads with mem_rdata=0x80F1_7F82:
  - LB addr 0x0 -> 0xFFFFFF82; LBU addr 0x0 -> 0x00000082.
  - LB addr 0x1 -> 0x0000007F.
  - LH addr 0x2 -> 0xFFFF80F1; LHU addr 0x2 -> 0x000080F1.
  - LW addr 0x0 -> 0x80F17F82.
- LW addr=0x6, SH addr=0x1, load funct3=011 -> resp_err=1 one cycle after accept, mem_req never asserts.
- TIMEOUT_CYCLES=4, mem_ack tied 0 -> mem_req high exactly 4 cycles then low; resp_err=1, rdata=0; a second case with ack on the 4th cycle -> err=0.
- Back-to-back requests with req_valid held high -> next accept in cycle after resp_valid; assert rst_n low while mem_req=1 -> mem_req and req_ready go 0 immediately, no resp_valid after release.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundle of core-side request/response and memory-side bus signals for the load/store unit.
// The slave modport is the unit's view; master is the core plus memory environment.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: decodes RV32I load/store requests, issues word-aligned memory accesses with
// byte strobes, and returns extended load data or an error (misaligned, illegal, timeout).
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input logic               clk,
    input logic               rst_n,
    load_store_unit_if.slave  bus_io
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam int unsigned TimeoutLastInt = TimeoutEn ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TimeoutLastInt);

    state_e               state_q, state_d;
    logic                 ready_q, ready_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 is_store_q, is_store_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic                 legal;
    logic                 misaligned;
    logic [31:0]          shifted;
    logic [31:0]          load_ext;
    logic [31:0]          fmt_wdata;
    logic [3:0]           fmt_wstrb;
    logic                 in_access;
    logic                 in_resp;

    // Request decode is only consumed on the accept edge; it never reaches mem_* directly.
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        if (bus_io.req_is_store) begin
            legal = (bus_io.req_funct3 == 3'b000) || (bus_io.req_funct3 == 3'b001) ||
                    (bus_io.req_funct3 == 3'b010);
        end else begin
            legal = (bus_io.req_funct3 == 3'b000) || (bus_io.req_funct3 == 3'b001) ||
                    (bus_io.req_funct3 == 3'b010) || (bus_io.req_funct3 == 3'b100) ||
                    (bus_io.req_funct3 == 3'b101);
        end
        if (bus_io.req_funct3[1:0] == 2'b01) begin
            misaligned = bus_io.req_addr[0];
        end else if (bus_io.req_funct3[1:0] == 2'b10) begin
            misaligned = (bus_io.req_addr[1:0] != 2'b00);
        end
    end

    always_comb begin
        fmt_wdata = wdata_q;
        fmt_wstrb = 4'b1111;
        case (funct3_q[1:0])
            2'b00: begin
                fmt_wdata = {4{wdata_q[7:0]}};
                fmt_wstrb = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                fmt_wdata = {2{wdata_q[15:0]}};
                fmt_wstrb = 4'b0011 << addr_q[1:0];
            end
            default: begin
                fmt_wdata = wdata_q;
                fmt_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        shifted  = bus_io.mem_rdata >> {addr_q[1:0], 3'b000};
        load_ext = shifted;
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus_io.req_valid && ready_q) begin
                    is_store_d = bus_io.req_is_store;
                    funct3_d   = bus_io.req_funct3;
                    addr_d     = bus_io.req_addr;
                    wdata_d    = bus_io.req_wdata;
                    rdata_d    = '0;
                    if (!legal || misaligned) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StAccess;
                        err_d   = 1'b0;
                    end
                end
            end
            StAccess: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (bus_io.mem_ack) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    rdata_d = is_store_q ? 32'h0 : load_ext;
                end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            cnt_q      <= cnt_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign in_access = (state_q == StAccess);
    assign in_resp   = (state_q == StResp);

    assign bus_io.req_ready  = ready_q;
    assign bus_io.resp_valid = in_resp;
    assign bus_io.resp_rdata = in_resp ? rdata_q : 32'h0;
    assign bus_io.resp_err   = in_resp & err_q;
    assign bus_io.mem_req    = in_access;
    assign bus_io.mem_we     = in_access & is_store_q;
    assign bus_io.mem_addr   = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_io.mem_wdata  = (in_access && is_store_q) ? fmt_wdata : 32'h0;
    assign bus_io.mem_wstrb  = (in_access && is_store_q) ? fmt_wstrb : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, errors, timeout, back-to-back and reset.
module tb_load_store_unit;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    load_store_unit_if bus ();

    load_store_unit #(
        .TIMEOUT_CYCLES(4),
        .CNT_WIDTH     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Drives one request and gathers what the unit presents; no comparisons here.
    task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a, d, rd,
                              output logic o_req, o_we, output logic [31:0] o_addr, o_wdata,
                              output logic [3:0] o_strb, output logic o_rv, o_err,
                              output logic [31:0] o_rdata);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
        o_req   = bus.mem_req;
        o_we    = bus.mem_we;
        o_addr  = bus.mem_addr;
        o_wdata = bus.mem_wdata;
        o_strb  = bus.mem_wstrb;
        if (bus.mem_req) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd;
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0;
        end
        o_rv    = bus.resp_valid;
        o_err   = bus.resp_err;
        o_rdata = bus.resp_rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.req_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", bus.req_ready); else passed++;
        total++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req got %b exp 0", bus.mem_req); else passed++;
        total++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b exp 0", bus.resp_valid); else passed++;
        total++; if (bus.mem_wstrb !== 4'b0) $display("FAIL rst_wstrb got %b exp 0000", bus.mem_wstrb); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) $display("FAIL post_rst_ready got %b exp 1", bus.req_ready); else passed++;
    endtask

    task automatic test_stores();
        logic rq, we, rv, er;
        logic [31:0] ad, wd, rdt;
        logic [3:0] sb;
        run_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, rq, we, ad, wd, sb, rv, er, rdt);
        total++; if (rq !== 1'b1) $display("FAIL sw_mem_req got %b exp 1", rq); else passed++;
        total++; if (we !== 1'b1) $display("FAIL sw_we got %b exp 1", we); else passed++;
        total++; if (ad !== 32'h10) $display("FAIL sw_addr got %h exp 00000010", ad); else passed++;
        total++; if (sb !== 4'b1111) $display("FAIL sw_strb got %b exp 1111", sb); else passed++;
        total++; if (wd !== 32'hDEADBEEF) $display("FAIL sw_wdata got %h exp deadbeef", wd); else passed++;
        total++; if (rv !== 1'b1 || er !== 1'b0 || rdt !== 32'h0)
            $display("FAIL sw_resp got v=%b e=%b d=%h exp v=1 e=0 d=0", rv, er, rdt); else passed++;
        run_access(1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, rq, we, ad, wd, sb, rv, er, rdt);
        total++; if (ad !== 32'h10) $display("FAIL sb_addr got %h exp 00000010", ad); else passed++;
        total++; if (sb !== 4'b1000) $display("FAIL sb_strb got %b exp 1000", sb); else passed++;
        total++; if (wd !== 32'hA5A5A5A5) $display("FAIL sb_wdata got %h exp a5a5a5a5", wd); else passed++;
        run_access(1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, rq, we, ad, wd, sb, rv, er, rdt);
        total++; if (sb !== 4'b1100) $display("FAIL sh_strb got %b exp 1100", sb); else passed++;
        total++; if (wd !== 32'h12341234) $display("FAIL sh_wdata got %h exp 12341234", wd); else passed++;
        total++; if (rv !== 1'b1 || er !== 1'b0)
            $display("FAIL sh_resp got v=%b e=%b exp v=1 e=0", rv, er); else passed++;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010};
        logic [31:0] ads [6] = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h2, 32'h0};
        logic [31:0] exps[6] = '{32'hFFFFFF82, 32'h00000082, 32'h0000007F,
                                 32'hFFFF80F1, 32'h000080F1, 32'h80F17F82};
        logic rq, we, rv, er;
        logic [31:0] ad, wd, rdt;
        logic [3:0] sb;
        for (int i = 0; i < 6; i++) begin
            run_access(1'b0, f3s[i], ads[i], 32'hFFFFFFFF, 32'h80F17F82,
                       rq, we, ad, wd, sb, rv, er, rdt);
            total++; if (rq !== 1'b1 || we !== 1'b0 || sb !== 4'b0000 || ad !== 32'h0)
                $display("FAIL load%0d_bus got req=%b we=%b strb=%b addr=%h exp 1 0 0000 0",
                         i, rq, we, sb, ad); else passed++;
            total++; if (rv !== 1'b1 || er !== 1'b0 || rdt !== exps[i])
                $display("FAIL load%0d_data got v=%b e=%b d=%h exp v=1 e=0 d=%h",
                         i, rv, er, rdt, exps[i]); else passed++;
        end
    endtask

    task automatic test_errors();
        logic        sts [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] ads [4] = '{32'h6, 32'h1, 32'h0, 32'h0};
        logic rq, we, rv, er;
        logic [31:0] ad, wd, rdt;
        logic [3:0] sb;
        for (int i = 0; i < 4; i++) begin
            run_access(sts[i], f3s[i], ads[i], 32'h12345678, 32'hFFFFFFFF,
                       rq, we, ad, wd, sb, rv, er, rdt);
            total++; if (rq !== 1'b0) $display("FAIL err%0d_mem_req got %b exp 0", i, rq); else passed++;
            total++; if (rv !== 1'b1 || er !== 1'b1 || rdt !== 32'h0)
                $display("FAIL err%0d_resp got v=%b e=%b d=%h exp v=1 e=1 d=0", i, rv, er, rdt);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        int cnt;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        cnt = 0;
        while (bus.mem_req && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        total++; if (cnt !== 4) $display("FAIL to_req_cycles got %0d exp 4", cnt); else passed++;
        total++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0)
            $display("FAIL to_resp got v=%b e=%b d=%h exp v=1 e=1 d=0",
                     bus.resp_valid, bus.resp_err, bus.resp_rdata); else passed++;
        // Ack arrives on the last cycle before the timeout would fire.
        @(negedge clk);
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            if (bus.mem_req) cnt++;
            if (k == 4) begin
                bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11223344;
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        total++; if (cnt !== 4) $display("FAIL to_ack_req_cycles got %0d exp 4", cnt); else passed++;
        total++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h11223344)
            $display("FAIL to_ack_resp got v=%b e=%b d=%h exp v=1 e=0 d=11223344",
                     bus.resp_valid, bus.resp_err, bus.resp_rdata); else passed++;
    endtask

    task automatic test_back_to_back();
        int req_idx[$];
        int resp_idx[$];
        logic prev_req;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h40; bus.req_wdata = 32'h0;
        prev_req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.mem_req && !prev_req) req_idx.push_back(i);
            if (bus.resp_valid) resp_idx.push_back(i);
            prev_req      = bus.mem_req;
            bus.mem_ack   = bus.mem_req;
            bus.mem_rdata = 32'hCAFE0000 + 32'(i);
            if (i == 7) bus.req_valid = 1'b0;
        end
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        total++; if (req_idx.size() !== 3 || resp_idx.size() !== 3)
            $display("FAIL b2b_counts got req=%0d resp=%0d exp 3 3", req_idx.size(), resp_idx.size());
        else passed++;
        total++; if (req_idx.size() < 3 || req_idx[0] !== 1 || req_idx[1] !== 4 || req_idx[2] !== 7)
            $display("FAIL b2b_req_cycles got %p exp 1 4 7", req_idx); else passed++;
        total++; if (resp_idx.size() < 3 || resp_idx[0] !== 2 || resp_idx[1] !== 5 || resp_idx[2] !== 8)
            $display("FAIL b2b_resp_cycles got %p exp 2 5 8", resp_idx); else passed++;
    endtask

    task automatic test_reset_mid_access();
        int seen;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h80; bus.req_wdata = 32'h5555AAAA;
        @(negedge clk);
        bus.req_valid = 1'b0;
        total++; if (bus.mem_req !== 1'b1) $display("FAIL mid_pre_req got %b exp 1", bus.mem_req); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b0)
            $display("FAIL mid_rst_drop got req=%b ready=%b exp 0 0", bus.mem_req, bus.req_ready);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_req) seen++;
        end
        bus.mem_ack = 1'b0;
        total++; if (seen !== 0) $display("FAIL mid_no_resp got %0d active cycles exp 0", seen); else passed++;
        total++; if (bus.req_ready !== 1'b1) $display("FAIL mid_ready_after got %b exp 1", bus.req_ready); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        test_reset();
        test_stores();
        test_loads();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
